sipo_rx: RTL and testbench
==========================

SIPO_RX -- requirements
Module: sipo_rx

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, giving the parallel word width in bits (legal range 2..32).
REQ-002 The block SHALL have parameter MSB_FIRST, default 1; 1 means the first serial bit lands in q[WIDTH-1], 0 means it lands in q[0].
REQ-003 The block SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port areset  input  1  asynchronous reset, active-low (0 = reset asserted).
REQ-005 The block SHALL have port ena  input  1  serial bit valid; sin is sampled only when ena=1.
REQ-006 The block SHALL have port sin  input  1  serial data bit.
REQ-007 The block SHALL have port sof  input  1  start of frame; qualified by ena, it marks sin as bit 0 of a new word.
REQ-008 The block SHALL have port q  output  WIDTH  last completed parallel word.
REQ-009 The block SHALL have port q_valid  output  1  q holds an unconsumed word.
REQ-010 The block SHALL have port q_ready  input  1  consumer accepts q when q_valid=1 and q_ready=1.
REQ-011 The block SHALL have port overrun  output  1  sticky flag: a completed word was dropped.
REQ-012 The block SHALL have port clr_ovr  input  1  synchronous clear of overrun.
REQ-013 The block SHALL have port busy  output  1  a partial word (1..WIDTH-1 bits) is held.

Function
REQ-014 The collector SHALL have two states: IDLE (bit count 0) and SHIFT (bit count 1..WIDTH-1).
- IDLE -> SHIFT on ena=1.
- SHIFT -> IDLE when the WIDTH-th bit is sampled.
REQ-015 Bit count SHALL increment by 1 on each ena=1 cycle and SHALL wrap from WIDTH-1 to 0 on word completion.
REQ-016 When ena=1 and sof=1, the block SHALL discard any partial word and take sin as bit 0; busy=1 next cycle (or a word completes if WIDTH bits are reached, not possible for WIDTH>=2).
REQ-017 When ena=0, sof SHALL be ignored and no state SHALL change in the collector.
REQ-018 On the edge that samples the WIDTH-th bit, the completed word SHALL be written to q when q_valid=0, or when q_valid=1 and q_ready=1 in the same cycle; q_valid SHALL be 1 after that edge.
- Latency: last bit sampled at edge N -> q/q_valid visible after edge N.
REQ-019 When q_valid=1 and q_ready=1 with no word completing, q_valid SHALL be 0 after the edge; q SHALL keep its value.
REQ-020 When a word completes while q_valid=1 and q_ready=0, the block SHALL drop the new word, keep q unchanged, and set overrun=1 after the edge.
REQ-021 overrun SHALL remain 1 until clr_ovr=1 or reset; if clr_ovr=1 in the same cycle as a new overrun event, overrun SHALL be 1 (set wins).
REQ-022 q SHALL be stable while q_valid=1 and q_ready=0.
REQ-023 busy SHALL equal 1 exactly when the collector is in SHIFT.

Reset
REQ-024 While areset=0, the block SHALL force state=IDLE, bit count=0, shift register=0, q=0, q_valid=0, overrun=0, busy=0, regardless of clk.
REQ-025 Reset asserted mid-word SHALL discard the partial word; the first ena=1 after release SHALL be bit 0.
REQ-026 Release of areset SHALL take effect at the next rising clk edge with no extra wait cycles.

Structure
REQ-027 A shared package sipo_pkg SHALL hold the state enumeration (IDLE, SHIFT) and the default WIDTH constant.
REQ-028 The serial shift/insert datapath SHALL be one sub-module, sipo_shift (WIDTH, MSB_FIRST, shift enable, restart, sin -> partial word); control, output buffer and flags SHALL stay in sipo_rx.

Verification (WIDTH=4)
REQ-029 Reset with MSB_FIRST=1: hold areset=0 for 2 cycles -> q=0, q_valid=0, overrun=0, busy=0.
REQ-030 Basic word: MSB_FIRST=1, ena=1 with sof on the first bit, sin=1,0,1,0, q_ready=1 -> q=4'b1010, q_valid=1 for one cycle after edge 4; with MSB_FIRST=0 -> q=4'b0101.
REQ-031 Gapped input: bits 1,1,0,1 with ena=0 cycles between them -> q=4'b1101, busy=1 across the gaps.
REQ-032 Restart: after 2 bits, sof=1 with bits 0,0,1,1 -> q=4'b0011; the earlier partial bits are discarded.
REQ-033 Overrun and simultaneity:
- q_ready=0, send 1010 then 0110 -> q=4'b1010, overrun=1.
- clr_ovr pulse -> overrun=0.
- Complete 1111 in the same cycle q_ready=1 -> q=4'b1111, q_valid stays 1, overrun stays 0.
REQ-034 Reset mid-word: after 2 bits, pulse areset=0, then send 1001 -> q=4'b1001, no residue from the earlier bits.

Source files
------------

// File: rtl/sipo_pkg.sv
// Shared types and constants for the serial-in / parallel-out receiver.
package sipo_pkg;

    // Collector state: IDLE holds no bits, SHIFT holds a partial word.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEFAULT_WIDTH = 4;

endpackage

// File: rtl/sipo_rx_if.sv
// Serial input, parallel output and status bundle for sipo_rx.
interface sipo_rx_if
    import sipo_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             ena;
    logic             sin;
    logic             sof;
    logic             q_ready;
    logic             clr_ovr;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             overrun;
    logic             busy;

    // Producer/consumer side.
    modport master (
        output ena, sin, sof, q_ready, clr_ovr,
        input  q, q_valid, overrun, busy
    );

    // Receiver side.
    modport slave (
        input  ena, sin, sof, q_ready, clr_ovr,
        output q, q_valid, overrun, busy
    );
endinterface

// File: rtl/sipo_shift.sv
// Shift/insert datapath: accumulates serial bits into a partial word.
// word_nxt is the value the register takes on this edge when shift_en=1,
// so the controller can capture a completed word on the same edge.
module sipo_shift
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             shift_en,
    input  logic             restart,
    input  logic             sin,
    output logic [WIDTH-1:0] word_nxt,
    output logic [WIDTH-1:0] word
);
    logic [WIDTH-1:0] base;

    // Restart starts from an empty word so stale bits never leak into q.
    always_comb begin
        base     = restart ? '0 : word;
        word_nxt = base;
        if (MSB_FIRST) word_nxt = {base[WIDTH-2:0], sin};
        else           word_nxt = {sin, base[WIDTH-1:1]};
    end

    // Partial word register.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)       word <= '0;
        else if (shift_en) word <= word_nxt;
    end
endmodule

// File: rtl/sipo_rx.sv
// Serial-to-parallel receiver: bit collector FSM, single-entry output
// buffer with ready/valid handshake, and sticky overrun flag.
module sipo_rx
    import sipo_pkg::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk,
    input  logic       areset,
    sipo_rx_if.slave   bus
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CW-1:0]    bidx;
    logic             complete;
    logic             restart;
    logic [WIDTH-1:0] word_nxt;
    logic [WIDTH-1:0] word;
    logic [WIDTH-1:0] q_r;
    logic             q_valid_r;
    logic             overrun_r;

    sipo_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_shift (
        .clk      (clk),
        .areset   (areset),
        .shift_en (bus.ena),
        .restart  (restart),
        .sin      (bus.sin),
        .word_nxt (word_nxt),
        .word     (word)
    );

    // Collector state and bit count.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state: sof forces the current bit to be bit 0 of a new word.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bidx     = bus.sof ? '0 : cnt_q;
        complete = 1'b0;
        restart  = bus.sof || (state_q == IDLE);
        if (bus.ena) begin
            if (bidx == LAST) begin
                complete = 1'b1;
                state_d  = IDLE;
                cnt_d    = '0;
            end else begin
                state_d  = SHIFT;
                cnt_d    = bidx + 1'b1;
            end
        end
    end

    // Output buffer: a completing word is stored only if the slot is free
    // or being drained this cycle; otherwise it is dropped.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset) begin
            q_r       <= '0;
            q_valid_r <= 1'b0;
        end else if (complete && (!q_valid_r || bus.q_ready)) begin
            q_r       <= word_nxt;
            q_valid_r <= 1'b1;
        end else if (!complete && q_valid_r && bus.q_ready) begin
            q_valid_r <= 1'b0;
        end
    end

    // Sticky overrun; a new drop beats a simultaneous clear.
    always_ff @(posedge clk or negedge areset) begin
        if (!areset)                                      overrun_r <= 1'b0;
        else if (complete && q_valid_r && !bus.q_ready)   overrun_r <= 1'b1;
        else if (bus.clr_ovr)                             overrun_r <= 1'b0;
    end

    assign bus.q       = q_r;
    assign bus.q_valid = q_valid_r;
    assign bus.overrun = overrun_r;
    assign bus.busy    = (state_q == SHIFT);
endmodule

// File: tb/tb_sipo_rx.sv
// Bench for sipo_rx: two instances (MSB-first and LSB-first) share one
// stimulus stream and are compared against a bit-list reference model.
module tb_sipo_rx;
    import sipo_pkg::*;

    localparam int W = 4;

    logic clk = 1'b0;
    logic areset = 1'b0;
    logic ena = 1'b0, sin = 1'b0, sof = 1'b0, q_ready = 1'b0, clr_ovr = 1'b0;

    sipo_rx_if #(.WIDTH(W)) ifa ();
    sipo_rx_if #(.WIDTH(W)) ifb ();

    assign ifa.ena = ena;     assign ifb.ena = ena;
    assign ifa.sin = sin;     assign ifb.sin = sin;
    assign ifa.sof = sof;     assign ifb.sof = sof;
    assign ifa.q_ready = q_ready; assign ifb.q_ready = q_ready;
    assign ifa.clr_ovr = clr_ovr; assign ifb.clr_ovr = clr_ovr;

    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_a (.clk(clk), .areset(areset), .bus(ifa));
    sipo_rx #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_b (.clk(clk), .areset(areset), .bus(ifb));

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: bits received so far in stream order, output slot.
    bit         bits[$];
    logic [W-1:0] mword;   // stream order: first bit at [W-1]
    bit         mvalid;
    bit         movr;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic model_reset();
        bits.delete();
        mword  = '0;
        mvalid = 1'b0;
        movr   = 1'b0;
    endtask

    // Advance the model by one clock edge using the current inputs.
    task automatic model_edge();
        bit done = 1'b0;
        bit drop = 1'b0;
        logic [W-1:0] w = '0;
        if (ena) begin
            if (sof) bits.delete();
            bits.push_back(sin);
            if (bits.size() == W) begin
                done = 1'b1;
                for (int i = 0; i < W; i++) w[W-1-i] = bits[i];
                bits.delete();
            end
        end
        if (done) begin
            if (!mvalid || q_ready) begin
                mword  = w;
                mvalid = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (mvalid && q_ready) begin
            mvalid = 1'b0;
        end
        if (drop)         movr = 1'b1;
        else if (clr_ovr) movr = 1'b0;
    endtask

    task automatic compare_all();
        chk("q_a",     32'(ifa.q),       32'(mword));
        chk("q_b",     32'(ifb.q),       32'(rev(mword)));
        chk("vld_a",   32'(ifa.q_valid), 32'(mvalid));
        chk("vld_b",   32'(ifb.q_valid), 32'(mvalid));
        chk("ovr_a",   32'(ifa.overrun), 32'(movr));
        chk("ovr_b",   32'(ifb.overrun), 32'(movr));
        chk("busy_a",  32'(ifa.busy),    32'(bits.size() != 0));
        chk("busy_b",  32'(ifb.busy),    32'(bits.size() != 0));
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        ena = 1'b0; sin = 1'b0; sof = 1'b0; clr_ovr = 1'b0;
    endtask

    // Send a word, first bit = w[W-1]; q_ready raised only on the last bit
    // when rdy_last is set, otherwise held at rdy.
    task automatic send_word(input logic [W-1:0] w, input bit use_sof,
                             input bit rdy, input bit rdy_last);
        for (int i = 0; i < W; i++) begin
            ena = 1'b1;
            sin = w[W-1-i];
            sof = use_sof && (i == 0);
            q_ready = (i == W-1) ? rdy_last : rdy;
            step();
        end
        idle_inputs();
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_q"},    32'(ifa.q),       32'h0);
        chk({tag, "_vld"},  32'(ifa.q_valid), 32'h0);
        chk({tag, "_ovr"},  32'(ifa.overrun), 32'h0);
        chk({tag, "_busy"}, 32'(ifa.busy),    32'h0);
        chk({tag, "_qb"},   32'(ifb.q),       32'h0);
    endtask

    initial begin
        // Reset held for two cycles.
        model_reset();
        areset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_zero("rst");
        areset = 1'b1;

        // Basic word with sof on the first bit, consumer always ready.
        send_word(4'b1010, 1'b1, 1'b1, 1'b1);
        chk("basic_qa",  32'(ifa.q), 32'hA);
        chk("basic_qb",  32'(ifb.q), 32'h5);
        chk("basic_vld", 32'(ifa.q_valid), 32'h1);
        q_ready = 1'b1;
        step();
        chk("basic_drain", 32'(ifa.q_valid), 32'h0);

        // Gapped input: ena=0 cycles between bits keep busy asserted.
        for (int i = 0; i < W; i++) begin
            ena = 1'b1; sin = (4'b1101 >> (W-1-i)) & 1'b1; sof = (i == 0);
            step();
            idle_inputs();
            if (i < W-1) begin
                step();
                chk("gap_busy", 32'(ifa.busy), 32'h1);
            end
        end
        chk("gap_q", 32'(ifa.q), 32'hD);
        step();

        // Restart: two stale bits then a fresh sof word.
        ena = 1'b1; sin = 1'b1; sof = 1'b1; step();
        sof = 1'b0; step();
        idle_inputs();
        send_word(4'b0011, 1'b1, 1'b1, 1'b1);
        chk("restart_q", 32'(ifa.q), 32'h3);
        step();

        // Overrun: second word dropped while first is unconsumed.
        send_word(4'b1010, 1'b0, 1'b0, 1'b0);
        send_word(4'b0110, 1'b0, 1'b0, 1'b0);
        chk("ovr_q",   32'(ifa.q),       32'hA);
        chk("ovr_set", 32'(ifa.overrun), 32'h1);
        clr_ovr = 1'b1; step(); clr_ovr = 1'b0;
        chk("ovr_clr", 32'(ifa.overrun), 32'h0);
        // Completion in the same cycle the held word is consumed.
        send_word(4'b1111, 1'b0, 1'b0, 1'b1);
        chk("simul_q",   32'(ifa.q),       32'hF);
        chk("simul_vld", 32'(ifa.q_valid), 32'h1);
        chk("simul_ovr", 32'(ifa.overrun), 32'h0);
        q_ready = 1'b1; step();

        // Set beats clear: overrun event and clr_ovr together.
        q_ready = 1'b0;
        send_word(4'b0001, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < W; i++) begin
            ena = 1'b1; sin = 1'b0; clr_ovr = (i == W-1);
            step();
        end
        idle_inputs();
        chk("set_wins", 32'(ifa.overrun), 32'h1);
        clr_ovr = 1'b1; q_ready = 1'b1; step(); clr_ovr = 1'b0;

        // Reset mid-word, checked asynchronously between edges.
        ena = 1'b1; sin = 1'b1; step(); step();
        idle_inputs();
        #1 areset = 1'b0;
        model_reset();
        #1;
        check_zero("arst");
        @(posedge clk);
        #1 areset = 1'b1;
        send_word(4'b1001, 1'b0, 1'b1, 1'b1);
        chk("arst_q",  32'(ifa.q),  32'h9);
        chk("arst_qb", 32'(ifb.q),  32'h9);

        // Randomized traffic against the model.
        for (int n = 0; n < 600; n++) begin
            ena     = ($urandom_range(0, 3) != 0);
            sin     = 1'($urandom);
            sof     = ($urandom_range(0, 9) == 0);
            q_ready = ($urandom_range(0, 2) == 0);
            clr_ovr = ($urandom_range(0, 15) == 0);
            step();
        end
        idle_inputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
